usb_fs_tx_pkt_buffer: RTL



---
 rtl/usb_fs_tx_pkt_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/usb_fs_tx_pkt_buffer.sv
// Single-packet IN-endpoint transmit buffer feeding the full-speed transmitter.
// Holds the payload after transmission until the endpoint acks or asks for a replay.
module usb_fs_tx_pkt_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          wr_full,
  output logic          wr_err,
  output logic [AW:0]   level,
  input  logic          send,
  input  logic [3:0]    send_pid,
  input  logic          ack,
  input  logic          retry,
  output logic          busy,
  output logic          sent,
  output logic          pkt_start,
  output logic [3:0]    pid,
  input  logic          pkt_end,
  output logic          tx_data_avail,
  input  logic          tx_data_get,
  output logic [7:0]    tx_data
);

  typedef enum logic [1:0] {StFill, StStart, StSending, StHold} state_e;

  localparam logic [AW:0] PtrOne  = (AW+1)'(1);
  localparam logic [AW:0] PtrFull = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]  pid_q, pid_d;
  logic        wr_err_q, wr_err_d;
  logic        sent_q, sent_d;
  logic [7:0]  tx_data_q;
  logic        mem_we;
  logic [7:0]  mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pid_d    = pid_q;
    mem_we   = 1'b0;
    sent_d   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (wr_en && !wr_full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
        end
        // A write coinciding with send is still part of the packet.
        if (send) begin
          pid_d    = send_pid;
          rd_ptr_d = '0;
          state_d  = StStart;
        end
      end
      StStart: state_d = StSending;
      StSending: begin
        if (pkt_end) begin
          state_d = StHold;
          sent_d  = 1'b1;
        end else if (tx_data_get && (rd_ptr_q != wr_ptr_q)) begin
          rd_ptr_d = rd_ptr_q + PtrOne;
        end
      end
      StHold: begin
        if (ack) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = StFill;
        end else if (retry) begin
          rd_ptr_d = '0;
          state_d  = StFill;
        end
      end
      default: state_d = StFill;
    endcase
    wr_err_d = wr_en && !mem_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFill;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pid_q     <= '0;
      wr_err_q  <= 1'b0;
      sent_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pid_q    <= pid_d;
      wr_err_q <= wr_err_d;
      sent_q   <= sent_d;
      // Prefetch the byte at the next read pointer so it is ready on the first SENDING cycle.
      if (state_d == StSending) begin
        tx_data_q <= mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign wr_full       = (wr_ptr_q == PtrFull);
  assign wr_err        = wr_err_q;
  assign level         = wr_ptr_q;
  assign busy          = (state_q != StFill);
  assign sent          = sent_q;
  assign pkt_start     = (state_q == StStart);
  assign pid           = pid_q;
  assign tx_data_avail = (state_q == StSending) && (rd_ptr_q != wr_ptr_q);
  assign tx_data       = tx_data_q;

endmodule
